// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a ready/valid packet stream through a 2-entry skid buffer.
// Optional define FIFO_STREAM_READER_PARITY_EN adds the m_parity output.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
`ifdef FIFO_STREAM_READER_PARITY_EN
   output logic                  m_parity,
`endif
   output logic [15:0]           pkt_count
);

   localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

`ifdef FIFO_STREAM_READER_PARITY_EN
   // Parity rides as an extra MSB of each buffer entry so it moves with its word.
   localparam int ENT_W = DATA_WIDTH + 1;
`else
   localparam int ENT_W = DATA_WIDTH;
`endif

   logic [1:0]       cnt;
   logic             inflight;
   logic [ENT_W-1:0] ent0;
   logic [ENT_W-1:0] ent1;
   logic [ENT_W-1:0] wr_ent;
   logic [7:0]       word_idx;
   logic             push;
   logic             pop;
   logic [2:0]       occ_next;

`ifdef FIFO_STREAM_READER_PARITY_EN
   assign wr_ent   = {^fifo_data, fifo_data};
   assign m_parity = ent0[DATA_WIDTH];
`else
   assign wr_ent   = fifo_data;
`endif

   assign push     = inflight;
   assign pop      = m_valid && m_ready;
   assign m_valid  = (cnt != 2'd0);
   assign m_data   = ent0[DATA_WIDTH-1:0];
   assign m_last   = m_valid && (word_idx == LAST_IDX);

   // Count the word already requested so a read is only issued when a slot is guaranteed;
   // pop cannot exceed cnt, so the subtraction never wraps.
   assign occ_next   = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = rst_n && !fifo_empty && (occ_next < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 2'd0;
         inflight  <= 1'b0;
         ent0      <= '0;
         ent1      <= '0;
         word_idx  <= 8'd0;
         pkt_count <= 16'd0;
      end else begin
         inflight <= fifo_rd_en;
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= wr_ent;
               else             ent1 <= wr_ent;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  ent0 <= wr_ent;
               end else begin
                  ent0 <= ent1;
                  ent1 <= wr_ent;
               end
            end
            default: ;
         endcase
         if (pop) begin
            word_idx <= (word_idx == LAST_IDX) ? 8'd0 : word_idx + 8'd1;
            if (m_last) pkt_count <= pkt_count + 16'd1;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && cnt == 2'd2));

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO word and stream data.
REQ-002 SHALL have parameter PKT_LEN, default 4, words per packet; legal range 1..256.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock shared with the upstream synchronous_fifo.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  DATA_WIDTH  FIFO data_out, valid one cycle after a sampled read.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-010 SHALL have port m_valid  output  1  stream data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts when high with m_valid.
REQ-012 SHALL have port m_last  output  1  final word of the current packet.
REQ-013 SHALL have port pkt_count  output  16  completed-packet counter.

Function
REQ-014 SHALL hold a 2-entry skid buffer; occupancy cnt ranges 0..2.
REQ-015 SHALL register inflight = fifo_rd_en of the previous cycle.
REQ-016 SHALL drive fifo_rd_en = !fifo_empty && (cnt + inflight - pop) < 2, with pop = m_valid && m_ready; the combinational path m_ready to fifo_rd_en is intentional.
REQ-017 SHALL write fifo_data into the buffer tail at the edge ending any cycle where inflight = 1, regardless of the current fifo_empty.
REQ-018 SHALL drive m_valid = (cnt != 0) and m_data = head entry, both from registers.
REQ-019 SHALL hold m_data and m_last stable while m_valid = 1 and m_ready = 0.
REQ-020 SHALL pop the head on pop; simultaneous push and pop leaves cnt unchanged and preserves order.
REQ-021 SHALL never overflow the buffer; a write with cnt = 2 and no pop is a design error, flagged by assertion.
REQ-022 SHALL assert m_valid two rising edges after the first edge sampling fifo_rd_en = 1 (two-cycle latency from empty deasserting).
REQ-023 SHALL sustain one word per cycle when fifo_empty = 0 and m_ready = 1 continuously.
REQ-024 SHALL keep an 8-bit word index, incremented on pop and wrapped to 0 after PKT_LEN-1.
REQ-025 SHALL drive m_last = m_valid && (word index == PKT_LEN-1); with PKT_LEN = 1, every word is last.
REQ-026 SHALL increment pkt_count on pop when m_last = 1; wraps 16'hFFFF to 0.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear cnt, inflight, word index, and pkt_count, and drive fifo_rd_en, m_valid, and m_last to 0 and m_data to 0.
REQ-028 SHALL discard an in-flight read when reset is asserted mid-operation; the word is lost.
REQ-029 SHALL hold fifo_rd_en at 0 while rst_n is low.

Configuration
REQ-030 SHALL, with FIFO_STREAM_READER_PARITY_EN defined, add output m_parity (1 bit) = XOR-reduction of m_data, registered alongside the head entry.
REQ-031 SHALL, without FIFO_STREAM_READER_PARITY_EN, omit the m_parity port and logic; all other behaviour is identical.

Verification
REQ-032 SHALL verify first word: FIFO holds 8'hA5, m_ready = 1 -> fifo_rd_en high in cycle 0, m_valid with m_data = 8'hA5 after edge 2, pkt_count = 0.
REQ-033 SHALL verify streaming: 8 words 0x01..0x08 with m_ready = 1 -> 8 consecutive valid cycles in order, m_last on 0x04 and 0x08, pkt_count = 2.
REQ-034 SHALL verify backpressure: m_ready = 0 for 5 cycles with a non-empty FIFO -> cnt saturates at 2, fifo_rd_en low, m_data held; on release, no word is lost or duplicated.
REQ-035 SHALL verify empty race: fifo_empty rises in the cycle after a read -> in-flight word is still captured; no further fifo_rd_en is issued.
REQ-036 SHALL verify reset mid-stream: rst_n low during cycle 3 of a packet -> all outputs 0 immediately; after release, the word index restarts at 0.
REQ-037 SHALL verify parity: with FIFO_STREAM_READER_PARITY_EN defined, m_data = 8'h07 -> m_parity = 1, and m_data = 8'h03 -> m_parity = 0.
